// File: rtl/dram_req_ctrl.sv
// In-order DRAM request sequencer: buffers read/write requests in a small FIFO, issues them one at
// a time to the bridge, and short-circuits repeated reads through a one-entry write-through cache.
module dram_req_ctrl #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_rw_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              c_in_valid_o,
    output logic              c_r_wb_o,
    output logic [ADDR_W-1:0] c_addr_o,
    output logic [DATA_W-1:0] c_data_w_o,
    input  logic              c_out_valid_i,
    input  logic [DATA_W-1:0] c_data_r_i,
    output logic              busy_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    // Request buffer
    logic              rw_mem    [FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_mem  [FIFO_DEPTH];
    logic [DATA_W-1:0] wdata_mem [FIFO_DEPTH];

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            full_q, full_d;
    logic            push, pop;

    state_e            state_q;
    logic              c_in_valid_q, c_r_wb_q, rsp_valid_q;
    logic [ADDR_W-1:0] c_addr_q;
    logic [DATA_W-1:0] c_data_w_q, rsp_rdata_q;
    logic              cache_valid_q;
    logic [ADDR_W-1:0] cache_tag_q;
    logic [DATA_W-1:0] cache_data_q;

    logic              head_rw;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic              head_hit;

    assign push = req_valid_i && !full_q;
    assign pop  = (state_q == StIdle) && (cnt_q != '0);

    assign head_rw    = rw_mem[rd_ptr_q];
    assign head_addr  = addr_mem[rd_ptr_q];
    assign head_wdata = wdata_mem[rd_ptr_q];
    assign head_hit   = head_rw && cache_valid_q && (cache_tag_q == head_addr);

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
        full_d = (cnt_d == CntW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rw_mem[wr_ptr_q]    <= req_rw_i;
            addr_mem[wr_ptr_q]  <= req_addr_i;
            wdata_mem[wr_ptr_q] <= req_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    // Sequencer: the C_* command registers double as the popped command, and are only loaded on a
    // miss so the bridge-side address/data keep their last values across cache hits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            c_in_valid_q  <= 1'b0;
            c_r_wb_q      <= 1'b0;
            c_addr_q      <= '0;
            c_data_w_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= '0;
        end else begin
            c_in_valid_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        if (head_hit) begin
                            rsp_rdata_q <= cache_data_q;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StResp;
                        end else begin
                            c_r_wb_q     <= head_rw;
                            c_addr_q     <= head_addr;
                            c_data_w_q   <= head_wdata;
                            c_in_valid_q <= 1'b1;
                            state_q      <= StIssue;
                        end
                    end
                end
                StIssue: state_q <= StWait;
                StWait: begin
                    if (c_out_valid_i) begin
                        if (c_r_wb_q) begin
                            rsp_rdata_q   <= c_data_r_i;
                            cache_valid_q <= 1'b1;
                            cache_tag_q   <= c_addr_q;
                            cache_data_q  <= c_data_r_i;
                        end else begin
                            rsp_rdata_q <= '0;
                            if (cache_valid_q && (cache_tag_q == c_addr_q)) begin
                                cache_data_q <= c_data_w_q;
                            end
                        end
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o  = !full_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign c_in_valid_o = c_in_valid_q;
    assign c_r_wb_o     = c_r_wb_q;
    assign c_addr_o     = c_addr_q;
    assign c_data_w_o   = c_data_w_q;
    assign busy_o       = (cnt_q != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_dram_req_ctrl.sv
// Scoreboard bench for dram_req_ctrl: stimulus queues expected responses and bridge requests, a
// bridge model and a response monitor pop and compare them independently.
module tb_dram_req_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        c_in_valid;
    logic        c_r_wb;
    logic [7:0]  c_addr;
    logic [63:0] c_data_w;
    logic        c_out_valid;
    logic [63:0] c_data_r;
    logic        busy;

    dram_req_ctrl #(
        .ADDR_W    (8),
        .DATA_W    (64),
        .FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_rw_i     (req_rw),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .c_in_valid_o (c_in_valid),
        .c_r_wb_o     (c_r_wb),
        .c_addr_o     (c_addr),
        .c_data_w_o   (c_data_w),
        .c_out_valid_i(c_out_valid),
        .c_data_r_i   (c_data_r),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    logic [63:0] exp_rsp [$];
    logic [72:0] exp_br  [$];  // {rw, addr, wdata}

    // Bridge model: a word memory behind a fixed, programmable delay
    logic [63:0] bmem [256];
    int          br_delay = 5;
    int          br_cnt = 0;
    int          cin_cyc = 0;
    int          cov_cyc = 0;
    bit          br_busy = 0;
    bit          spur = 0;

    initial begin
        int          br_left;
        logic        br_rw;
        logic [7:0]  br_addr;
        logic [63:0] br_wdata;
        logic [72:0] e;
        for (int i = 0; i < 256; i++) bmem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        bmem[8'h10] = 64'h0123_4567_89AB_CDEF;
        c_out_valid = 1'b0;
        c_data_r    = '0;
        br_left     = 0;
        br_rw       = 1'b0;
        br_addr     = '0;
        br_wdata    = '0;
        forever begin
            @(negedge clk);
            c_out_valid = 1'b0;
            if (!rst_n) begin
                br_busy = 0;
            end else begin
                if (br_busy) begin
                    br_left--;
                    if (br_left == 0) begin
                        check("bridge_rw_held", 64'(c_r_wb), 64'(br_rw));
                        check("bridge_addr_held", 64'(c_addr), 64'(br_addr));
                        check("bridge_wdata_held", c_data_w, br_wdata);
                        if (br_rw) c_data_r = bmem[br_addr];
                        else bmem[br_addr] = br_wdata;
                        c_out_valid = 1'b1;
                        cov_cyc = cyc;
                        br_busy = 0;
                    end
                end else if (spur) begin
                    c_data_r    = 64'hDEAD_BEEF_DEAD_BEEF;
                    c_out_valid = 1'b1;
                    spur        = 0;
                end
                if (c_in_valid) begin
                    cin_cyc = cyc;
                    br_cnt++;
                    if (exp_br.size() == 0) begin
                        check("bridge_unexpected_req", 64'(1), 64'(0));
                    end else begin
                        e = exp_br.pop_front();
                        check("bridge_req_rw", 64'(c_r_wb), 64'(e[72]));
                        check("bridge_req_addr", 64'(c_addr), 64'(e[71:64]));
                        if (!e[72]) check("bridge_req_wdata", c_data_w, e[63:0]);
                    end
                    br_rw    = c_r_wb;
                    br_addr  = c_addr;
                    br_wdata = c_data_w;
                    br_left  = br_delay;
                    br_busy  = 1;
                end
            end
        end
    end

    // Response monitor
    int rsp_cyc = 0;
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                rsp_cyc = cyc;
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", 64'(1), 64'(0));
                end else begin
                    e = exp_rsp.pop_front();
                    check("rsp_rdata", rsp_rdata, e);
                end
            end
        end
    end

    // Call at a negedge; returns at the negedge after the acceptance edge, req_valid still high
    task automatic push(input logic rw, input logic [7:0] a, input logic [63:0] wd,
                        input logic [63:0] exp, input bit miss, output bit stalled,
                        output int acc);
        stalled   = 0;
        acc       = 0;
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = a;
        req_wdata = wd;
        for (int i = 0; i < 300 && !req_ready; i++) begin
            stalled = 1;
            @(negedge clk);
        end
        if (!req_ready) begin
            check("push_timeout", 64'(1), 64'(0));
            req_valid = 1'b0;
        end else begin
            exp_rsp.push_back(exp);
            if (miss) exp_br.push_back({rw, a, wd});
            @(negedge clk);
            acc = cyc;
        end
    endtask

    task automatic drain(input int budget);
        int i;
        req_valid = 1'b0;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_rsp.size() == 0 && exp_br.size() == 0 && !busy) break;
        end
        if (i == budget) check("drain_timeout", 64'(1), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stalled;
        int acc;
        int cnt0;
        int stall_idx;
        logic [63:0] burst_exp [6];
        logic        burst_rw  [6];
        logic [7:0]  burst_addr[6];
        logic [63:0] burst_wd  [6];
        bit          burst_miss[6];

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_c_in_valid", 64'(c_in_valid), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rsp_rdata", rsp_rdata, 64'(0));
        check("rst_c_addr", 64'(c_addr), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Cold read miss with 5-cycle bridge
        br_delay = 5;
        push(1'b1, 8'h10, 64'h0, 64'h0123_4567_89AB_CDEF, 1, stalled, acc);
        drain(100);
        check("miss_cin_latency", 64'(cin_cyc - acc), 64'(1));
        check("miss_bridge_delay", 64'(cov_cyc - cin_cyc), 64'(5));
        check("miss_rsp_after_cov", 64'(rsp_cyc - cov_cyc), 64'(1));
        check("busy_drop", 64'(cyc - rsp_cyc), 64'(1));

        // Repeat read hits; next address misses
        cnt0 = br_cnt;
        push(1'b1, 8'h10, 64'h0, 64'h0123_4567_89AB_CDEF, 0, stalled, acc);
        drain(100);
        check("hit_rsp_latency", 64'(rsp_cyc - acc), 64'(1));
        check("hit_no_bridge", 64'(br_cnt), 64'(cnt0));
        br_delay = 3;
        push(1'b1, 8'h11, 64'h0, 64'hA5A5_0000_0000_0011, 1, stalled, acc);
        drain(100);
        check("miss11_bridge", 64'(br_cnt), 64'(cnt0 + 1));

        // Write-through updates cached 0x10 word (cache currently holds 0x11, so re-read 0x10)
        push(1'b1, 8'h10, 64'h0, 64'h0123_4567_89AB_CDEF, 1, stalled, acc);
        drain(100);
        push(1'b0, 8'h10, 64'hFFFF_0000_FFFF_0000, 64'h0, 1, stalled, acc);
        drain(100);
        cnt0 = br_cnt;
        push(1'b1, 8'h10, 64'h0, 64'hFFFF_0000_FFFF_0000, 0, stalled, acc);
        drain(100);
        check("wt_hit_no_bridge", 64'(br_cnt), 64'(cnt0));

        // Burst of 6 with slow bridge: one in flight plus four buffered before stall
        burst_rw   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        burst_addr = '{8'h20, 8'h21, 8'h21, 8'h21, 8'h21, 8'h21};
        burst_wd   = '{64'h0, 64'h1111_2222_3333_4444, 64'h0, 64'h0,
                       64'h5555_6666_7777_8888, 64'h0};
        burst_exp  = '{64'hA5A5_0000_0000_0020, 64'h0, 64'h1111_2222_3333_4444,
                       64'h1111_2222_3333_4444, 64'h0, 64'h5555_6666_7777_8888};
        burst_miss = '{1, 1, 1, 0, 1, 0};
        br_delay  = 20;
        cnt0      = br_cnt;
        stall_idx = -1;
        for (int i = 0; i < 6; i++) begin
            push(burst_rw[i], burst_addr[i], burst_wd[i], burst_exp[i], burst_miss[i],
                 stalled, acc);
            if (stalled && stall_idx < 0) stall_idx = i;
        end
        drain(600);
        check("burst_first_stall", 64'(stall_idx), 64'(5));
        check("burst_bridge_cnt", 64'(br_cnt), 64'(cnt0 + 4));

        // Spurious completion in IDLE is ignored
        spur = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("spur_busy", 64'(busy), 64'(0));
        end
        push(1'b1, 8'h21, 64'h0, 64'h5555_6666_7777_8888, 0, stalled, acc);
        drain(100);
        check("spur_then_hit_latency", 64'(rsp_cyc - acc), 64'(1));

        // Asynchronous reset mid-WAIT
        br_delay = 30;
        push(1'b1, 8'h30, 64'h0, 64'hA5A5_0000_0000_0030, 1, stalled, acc);
        req_valid = 1'b0;
        for (int i = 0; i < 50 && !br_busy; i++) @(negedge clk);
        check("rst_test_in_wait", 64'(br_busy), 64'(1));
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_c_in_valid", 64'(c_in_valid), 64'(0));
        check("arst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("arst_req_ready", 64'(req_ready), 64'(1));
        check("arst_busy", 64'(busy), 64'(0));
        exp_rsp.delete();
        exp_br.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        br_delay = 2;
        cnt0 = br_cnt;
        push(1'b1, 8'h10, 64'h0, 64'hFFFF_0000_FFFF_0000, 1, stalled, acc);
        drain(100);
        check("post_rst_miss", 64'(br_cnt), 64'(cnt0 + 1));
        check("post_rst_cin_latency", 64'(cin_cyc - acc), 64'(1));

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
